// File: rtl/uart_tx_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_shifter_if
// Purpose  : Byte handshake between a producer and the UART transmit shifter.
// Revision : 1.0
// ============================================================================
interface uart_tx_shifter_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_shifter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_shifter
// Purpose  : Serialises one byte per 10-bit UART frame; per-bit periods come
//            from an external timing ROM with 2-cycle read latency.
// Revision : 1.0
// ============================================================================
module uart_tx_shifter #(
    parameter int WIDTH = 8
) (
    input  wire logic             CLOCK,
    input  wire logic             RESET_N,
    uart_tx_shifter_if.slave      tx_if,
    output logic [3:0]            rom_addr,
    input  wire logic [WIDTH-1:0] rom_data,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] C_MIN_PERIOD = WIDTH'(3);
    localparam logic [WIDTH-1:0] C_ONE        = WIDTH'(1);
    localparam logic [3:0]       C_LAST_DATA  = 4'd8;
    localparam logic [3:0]       C_STOP_IDX   = 4'd9;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_warm;
    logic             w_warm_nxt;
    logic [3:0]       r_idx;
    logic [3:0]       w_idx_nxt;
    logic [3:0]       r_rom_addr;
    logic [3:0]       w_rom_addr_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_tx;
    logic             w_tx_nxt;
    logic             r_done;
    logic             w_done_nxt;

    logic [WIDTH-1:0] w_period;
    logic             w_expire;

    // Periods below 3 would let a bit end before its prefetched ROM word lands.
    assign w_period = (rom_data < C_MIN_PERIOD) ? C_MIN_PERIOD : rom_data;
    assign w_expire = (r_cnt <= C_ONE);

    assign tx_if.tx_ready = (r_state == ST_IDLE);
    assign busy           = (r_state == ST_SHIFT);
    assign rom_addr       = r_rom_addr;
    assign tx             = r_tx;
    assign done           = r_done;

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_state    <= ST_WARM;
            r_warm     <= 1'b0;
            r_idx      <= 4'd0;
            r_rom_addr <= 4'd0;
            r_cnt      <= '0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_warm     <= w_warm_nxt;
            r_idx      <= w_idx_nxt;
            r_rom_addr <= w_rom_addr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_warm_nxt     = r_warm;
        w_idx_nxt      = r_idx;
        w_rom_addr_nxt = r_rom_addr;
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_tx_nxt       = r_tx;
        w_done_nxt     = 1'b0;

        case (r_state)
            ST_WARM: begin
                // Two cycles of address 0 let the ROM pipeline settle on index 0.
                w_rom_addr_nxt = 4'd0;
                w_tx_nxt       = 1'b1;
                if (r_warm) begin
                    w_state_nxt = ST_IDLE;
                    w_warm_nxt  = 1'b0;
                end else begin
                    w_warm_nxt  = 1'b1;
                end
            end

            ST_IDLE: begin
                w_rom_addr_nxt = 4'd0;
                w_tx_nxt       = 1'b1;
                if (tx_if.tx_valid) begin
                    w_state_nxt    = ST_SHIFT;
                    w_shift_nxt    = tx_if.tx_data;
                    w_tx_nxt       = 1'b0;
                    w_cnt_nxt      = w_period;
                    w_idx_nxt      = 4'd0;
                    w_rom_addr_nxt = 4'd1;
                end
            end

            ST_SHIFT: begin
                if (!w_expire) begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end else if (r_idx == C_STOP_IDX) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                    w_tx_nxt    = 1'b1;
                    w_idx_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + 4'd1;
                    w_cnt_nxt = w_period;
                    if (r_idx == C_LAST_DATA) begin
                        // Entering the stop bit: prefetch the next frame's start period.
                        w_tx_nxt       = 1'b1;
                        w_rom_addr_nxt = 4'd0;
                    end else begin
                        w_tx_nxt       = r_shift[0];
                        w_shift_nxt    = {1'b0, r_shift[7:1]};
                        w_rom_addr_nxt = r_idx + 4'd2;
                    end
                end
            end

            default: begin
                w_state_nxt = ST_WARM;
                w_warm_nxt  = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_shifter.md
UART_TX_SHIFTER -- requirements
Module: uart_tx_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the bit-period count width; it matches the timing ROM data width.
REQ-002 SHALL have port CLOCK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port tx_data, input, 8 bits: the byte to send.
REQ-005 SHALL have port tx_valid, input, 1 bit: tx_data is valid.
REQ-006 SHALL have port tx_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-007 SHALL have port rom_addr, output, 4 bits, registered: bit-index address to the timing ROM.
REQ-008 SHALL have port rom_data, input, WIDTH bits: per-bit period in CLOCK cycles, valid 2 cycles after rom_addr changes.
REQ-009 SHALL have port tx, output, 1 bit, registered: the serial line, idle high.
REQ-010 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle pulse on frame completion.

Function
REQ-012 SHALL send a 10-bit frame: index 0 start (0), indexes 1-8 tx_data LSB first, index 9 stop (1).
REQ-013 SHALL implement states WARM, IDLE, SHIFT; WARM->IDLE after exactly 2 cycles; IDLE->SHIFT on accept; SHIFT->IDLE after the last cycle of index 9.
REQ-014 SHALL accept a byte when tx_valid && tx_ready at a rising edge, latching tx_data into an internal shift register.
REQ-015 SHALL drive tx_ready high only in IDLE; tx_valid SHALL be ignored in WARM and SHIFT.
REQ-016 SHALL hold rom_addr = 0 in WARM and IDLE, so rom_data holds the index-0 period whenever tx_ready is high.
REQ-017 SHALL, on accept, drive tx = 0 from the next cycle and load the down-counter with rom_data (index 0).
REQ-018 SHALL, at the start of bit index i, set rom_addr to i+1 for i in 0..8, and to 0 for i = 9 (prefetch of the next start bit).
REQ-019 SHALL hold each bit on tx for exactly N cycles, where N is the rom_data value sampled at that bit's start.
REQ-020 SHALL treat a sampled N < 3 as 3, so that the 2-cycle ROM latency is always covered by prefetch.
REQ-021 SHALL, when the counter expires, load the next bit value and the new N (already valid through prefetch) on the same edge, with no gap cycles between bits.
REQ-022 SHALL, after index 9 completes, enter IDLE with tx = 1, assert done for exactly that first IDLE cycle, and assert tx_ready in the same cycle.
REQ-023 SHALL assert busy exactly while in SHIFT.
REQ-024 SHALL perform counter arithmetic in WIDTH bits with no wrap; the counter SHALL never decrement below 1.

Reset
REQ-025 SHALL, when RESET_N is low at an edge (including mid-frame), set state = WARM, tx = 1, tx_ready = 0, busy = 0, done = 0, rom_addr = 0, counter = 0 and shift register = 0.
REQ-026 SHALL, after RESET_N rises, hold tx_ready low for exactly 2 cycles (WARM) before IDLE.
REQ-027 SHALL NOT emit a done pulse for a frame aborted by reset.

Verification
REQ-028 Bench SHALL cover: ROM = 168 + mask 0x3DF; send 0x55 -> tx shows 0,1,0,1,0,1,0,1,0,1 with bit periods 169 each except bit 5 = 168; total 1689 cycles; done pulses once.
REQ-029 Bench SHALL cover: tx_valid held high with 0xA3 then 0x3C -> second start bit begins exactly 1 cycle after the first frame's done cycle; no period error on the second frame's start bit.
REQ-030 Bench SHALL cover: RESET_N low at cycle 500 of a frame -> next edge tx = 1, busy = 0, no done; tx_ready = 1 exactly 2 cycles after RESET_N rises.
REQ-031 Bench SHALL cover: tx_valid high during WARM and during SHIFT -> no accept; the in-flight byte is unchanged.
REQ-032 Bench SHALL cover: ROM returns 1 for index 3 -> that bit lasts 3 cycles; all other bits are unaffected.
REQ-033 Bench SHALL cover: rom_addr sequence per frame -> 0 (idle), then 1..9, then 0 at stop-bit start; each value holds for one full bit period.
